// File: rtl/line_draw_pkg.sv
// Shared constants and state encoding for the Bresenham line draw engine.
package line_draw_pkg;

  // Default coordinate width, matching the AHB coordinate slave registers.
  localparam int COORD_W = 9;

  // Signed error-term width: room for 2*err plus dx/dy without overflow.
  localparam int ERR_W = COORD_W + 3;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: given the current pixel and error term,
// produce the next pixel and error. Both axis adjustments use the old error.
module bresenham_step #(
  parameter int COORD_W = 9,
  parameter int ERR_W   = 12
) (
  input  logic               [COORD_W-1:0] pix_x,
  input  logic               [COORD_W-1:0] pix_y,
  input  logic signed        [ERR_W-1:0]   err,
  input  logic signed        [ERR_W-1:0]   dx,
  input  logic signed        [ERR_W-1:0]   dy,
  input  logic                             sx_neg,
  input  logic                             sy_neg,
  output logic               [COORD_W-1:0] next_pix_x,
  output logic               [COORD_W-1:0] next_pix_y,
  output logic signed        [ERR_W-1:0]   next_err
);

  logic signed [ERR_W-1:0] w_e2;
  logic                    w_step_x;
  logic                    w_step_y;

  // Decide which axes advance and accumulate the error adjustments.
  always_comb begin
    w_e2       = err <<< 1;
    w_step_x   = (w_e2 >= dy);
    w_step_y   = (w_e2 <= dx);
    next_err   = err;
    next_pix_x = pix_x;
    next_pix_y = pix_y;
    if (w_step_x) begin
      next_err   = next_err + dy;
      next_pix_x = sx_neg ? (pix_x - {{(COORD_W-1){1'b0}}, 1'b1})
                          : (pix_x + {{(COORD_W-1){1'b0}}, 1'b1});
    end else begin
      next_pix_x = pix_x;
    end
    if (w_step_y) begin
      next_err   = next_err + dx;
      next_pix_y = sy_neg ? (pix_y - {{(COORD_W-1){1'b0}}, 1'b1})
                          : (pix_y + {{(COORD_W-1){1'b0}}, 1'b1});
    end else begin
      next_pix_y = pix_y;
    end
  end

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line draw engine: latches a line request, then streams one pixel
// per accepted valid/ready handshake and pulses done after the last pixel.
module line_draw_engine #(
  parameter int COORD_W = 9
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready
);

  import line_draw_pkg::*;

  // Error width tracks the actual coordinate width of this instance.
  localparam int W_ERR = COORD_W + 3;

  state_t r_state;
  state_t w_next_state;

  logic        [COORD_W-1:0] r_x2;
  logic        [COORD_W-1:0] r_y2;
  logic        [COORD_W-1:0] r_pix_x;
  logic        [COORD_W-1:0] r_pix_y;
  logic signed [W_ERR-1:0]   r_dx;
  logic signed [W_ERR-1:0]   r_dy;
  logic signed [W_ERR-1:0]   r_err;
  logic                      r_sx_neg;
  logic                      r_sy_neg;

  logic        [COORD_W-1:0] w_dx_abs;
  logic        [COORD_W-1:0] w_dy_abs;
  logic signed [W_ERR-1:0]   w_dx_s;
  logic signed [W_ERR-1:0]   w_dy_s;
  logic                      w_latch;
  logic                      w_accept;
  logic                      w_last;
  logic        [COORD_W-1:0] w_step_x;
  logic        [COORD_W-1:0] w_step_y;
  logic signed [W_ERR-1:0]   w_step_err;

  // Line parameters computed from the live inputs, used only on the latch cycle.
  always_comb begin
    if (x2 >= x1) begin
      w_dx_abs = x2 - x1;
    end else begin
      w_dx_abs = x1 - x2;
    end
    if (y2 >= y1) begin
      w_dy_abs = y2 - y1;
    end else begin
      w_dy_abs = y1 - y2;
    end
    w_dx_s = $signed({3'b000, w_dx_abs});
    w_dy_s = -$signed({3'b000, w_dy_abs});
  end

  assign w_latch  = (r_state == IDLE) && start;
  assign w_accept = (r_state == DRAW) && pix_ready;
  assign w_last   = (r_pix_x == r_x2) && (r_pix_y == r_y2);

  bresenham_step #(
    .COORD_W (COORD_W),
    .ERR_W   (W_ERR)
  ) u_step (
    .pix_x      (r_pix_x),
    .pix_y      (r_pix_y),
    .err        (r_err),
    .dx         (r_dx),
    .dy         (r_dy),
    .sx_neg     (r_sx_neg),
    .sy_neg     (r_sy_neg),
    .next_pix_x (w_step_x),
    .next_pix_y (w_step_y),
    .next_err   (w_step_err)
  );

  // State register with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start only matters in IDLE; last accepted pixel ends the line.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = DRAW;
        end else begin
          w_next_state = IDLE;
        end
      end
      DRAW: begin
        if (w_accept && w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = DRAW;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Latch line parameters on request and advance the pixel on each accepted handshake.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_x2     <= {COORD_W{1'b0}};
      r_y2     <= {COORD_W{1'b0}};
      r_pix_x  <= {COORD_W{1'b0}};
      r_pix_y  <= {COORD_W{1'b0}};
      r_dx     <= {W_ERR{1'b0}};
      r_dy     <= {W_ERR{1'b0}};
      r_err    <= {W_ERR{1'b0}};
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else if (w_latch) begin
      r_x2     <= x2;
      r_y2     <= y2;
      r_pix_x  <= x1;
      r_pix_y  <= y1;
      r_dx     <= w_dx_s;
      r_dy     <= w_dy_s;
      r_err    <= w_dx_s + w_dy_s;
      r_sx_neg <= !(x1 < x2);
      r_sy_neg <= !(y1 < y2);
    end else if (w_accept && !w_last) begin
      r_pix_x  <= w_step_x;
      r_pix_y  <= w_step_y;
      r_err    <= w_step_err;
    end else begin
      r_pix_x  <= r_pix_x;
      r_pix_y  <= r_pix_y;
      r_err    <= r_err;
    end
  end

  assign busy      = (r_state == DRAW);
  assign pix_valid = (r_state == DRAW);
  assign done      = (r_state == DONE);
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;

endmodule

// File: tb/tb_line_draw_engine.sv
// Scoreboard bench for line_draw_engine: a reference Bresenham model fills an
// expected-pixel queue per line; a monitor pops on every handshake.
module tb_line_draw_engine;

  localparam int CW = 9;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [CW-1:0] x1, y1, x2, y2;
  logic          start;
  logic          busy, done, pix_valid, pix_ready;
  logic [CW-1:0] pix_x, pix_y;

  typedef struct {int x; int y;} pt_t;
  pt_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int mode = 0;  // 0: ready always 1, 1: toggle, 2: random

  line_draw_engine #(.COORD_W(CW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .start(start), .busy(busy), .done(done),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: plain integer Bresenham, queueing every pixel of the line.
  task automatic model_line(input int ax, input int ay, input int bx, input int by);
    int x, y, dx, dy, sx, sy, err, e2;
    x = ax; y = ay;
    dx = iabs(bx - ax); dy = -iabs(by - ay);
    sx = (ax < bx) ? 1 : -1; sy = (ay < by) ? 1 : -1;
    err = dx + dy;
    forever begin
      exp_q.push_back('{x, y});
      if (x == bx && y == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Ready pattern driver, updated just after each rising edge.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge HCLK); #1;
      case (mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ~pix_ready;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare each handshake against the queue, check stalls hold.
  initial begin
    pt_t p;
    bit prev_stall;
    logic [CW-1:0] prev_x, prev_y;
    prev_stall = 1'b0;
    prev_x = '0; prev_y = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        check("busy_eq_valid", int'(busy), int'(pix_valid));
        if (prev_stall && pix_valid) begin
          check("stall_hold_x", int'(pix_x), int'(prev_x));
          check("stall_hold_y", int'(pix_y), int'(prev_y));
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pixel actual=(%0d,%0d) required=none", pix_x, pix_y);
          end else begin
            p = exp_q.pop_front();
            check("pix_x", int'(pix_x), p.x);
            check("pix_y", int'(pix_y), p.y);
          end
          accepted++;
        end
        if (done) check("done_queue_empty", exp_q.size(), 0);
        prev_stall = pix_valid && !pix_ready;
        prev_x = pix_x; prev_y = pix_y;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Issue one line, scramble inputs after latch, optionally re-pulse start mid-line.
  task automatic run_line(input int ax, input int ay, input int bx, input int by,
                          input int m, input bit interfere);
    int n, npix;
    bit got;
    model_line(ax, ay, bx, by);
    npix = ((iabs(bx - ax) > iabs(by - ay)) ? iabs(bx - ax) : iabs(by - ay)) + 1;
    accepted = 0;
    mode = m;
    @(posedge HCLK); #1;
    start = 1'b1; x1 = CW'(ax); y1 = CW'(ay); x2 = CW'(bx); y2 = CW'(by);
    @(posedge HCLK); #1;
    start = 1'b0;
    x1 = CW'($urandom); y1 = CW'($urandom); x2 = CW'($urandom); y2 = CW'($urandom);
    n = 0; got = 1'b0;
    while (n < 5000 && !got) begin
      @(negedge HCLK);
      n++;
      if (interfere && n == 3) begin
        start = 1'b1;
        x1 = CW'($urandom); y1 = CW'($urandom); x2 = CW'($urandom); y2 = CW'($urandom);
      end
      if (interfere && n == 4) start = 1'b0;
      if (done) begin
        got = 1'b1;
        check("busy_during_done", int'(busy), 0);
        check("valid_during_done", int'(pix_valid), 0);
      end
    end
    #1;
    check("done_seen", int'(got), 1);
    check("pixel_count", accepted, npix);
    check("queue_drained", exp_q.size(), 0);
    if (m == 0) check("cycles_to_done", n, npix + 1);
    @(negedge HCLK);
    check("done_one_cycle", int'(done), 0);
    check("idle_after_done", int'(busy), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    HRESET = 1'b1; start = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_pix_x", int'(pix_x), 0);
    check("rst_pix_y", int'(pix_y), 0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    run_line(0, 0, 5, 2, 0, 1'b0);
    run_line(10, 10, 10, 10, 0, 1'b0);
    run_line(8, 3, 2, 7, 1, 1'b0);
    run_line(0, 0, 511, 511, 0, 1'b0);
    run_line(0, 0, 9, 5, 2, 1'b1);
    run_line(511, 0, 0, 511, 2, 1'b0);

    // Reset while the 4th pixel of (0,0)->(20,0) is on the bus, with start coincident.
    model_line(0, 0, 20, 0);
    mode = 0;
    @(posedge HCLK); #1;
    start = 1'b1; x1 = 9'd0; y1 = 9'd0; x2 = 9'd20; y2 = 9'd0;
    @(posedge HCLK); #1;
    start = 1'b0;
    n = 0;
    while (n < 100 && !(pix_valid && pix_x == 9'd3)) begin
      @(negedge HCLK);
      n++;
    end
    check("reached_4th_pixel", int'(pix_x), 3);
    HRESET = 1'b1; start = 1'b1; x1 = 9'd7; y1 = 9'd7; x2 = 9'd30; y2 = 9'd12;
    @(posedge HCLK); #1;
    check("midrst_valid", int'(pix_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_pix_x", int'(pix_x), 0);
    check("midrst_pix_y", int'(pix_y), 0);
    HRESET = 1'b0; start = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge HCLK);
      check("post_rst_no_done", int'(done), 0);
      check("post_rst_idle", int'(busy), 0);
    end
    run_line(3, 4, 17, 9, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_line(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
               int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
